// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
//   Baud-rate tick generator for the UART path. Divides clk by a run-time
//   programmable divisor D to produce a one-cycle oversample strobe (os_tick).
//   Every OVERSAMPLE-th os_tick is a bit strobe (bit_tick), and the one half
//   way through a bit is a mid-bit strobe (mid_tick). The legacy square-wave
//   baud_clk toggles on every os_tick.
//
//   Optional build macro: FRAC_DIV_EN
//     Defined   : a FRAC_W-bit phase accumulator adds DIV_FRAC on every period
//                 wrap; a carry stretches the next period to D+1 cycles.
//     Undefined : every period is exactly D cycles.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   en        in   count enable, low freezes all counters
//   restart   in   phase restart pulse (RX start-bit alignment)
//   div_wr    in   divisor write strobe
//   div_in    in   new integer divisor (must be >= 2)
//   div_q     out  active divisor
//   div_err   out  one-cycle pulse after a rejected divisor write
//   os_tick   out  one-cycle oversample strobe
//   mid_tick  out  one-cycle mid-bit strobe
//   bit_tick  out  one-cycle end-of-bit strobe
//   baud_clk  out  square wave, toggles on each os_tick
// ----------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16,
   parameter int RESET_DIV  = CLK_HZ / (BAUD * OVERSAMPLE),
   parameter int FRAC_W     = 8,
   parameter int DIV_FRAC   = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic             div_wr,
   input  logic [DIV_W-1:0] div_in,
   output logic [DIV_W-1:0] div_q,
   output logic             div_err,
   output logic             os_tick,
   output logic             mid_tick,
   output logic             bit_tick,
   output logic             baud_clk
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [DIV_W-1:0] RESET_DIV_V = DIV_W'(RESET_DIV);
   localparam logic [OS_W-1:0]  OS_LAST     = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_MID      = OS_W'(OVERSAMPLE / 2 - 1);

   if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("baud_tick_gen: OVERSAMPLE must be even and >= 4");
   end
   if (FRAC_W < 1 || DIV_FRAC < 0) begin : g_bad_frac
      $error("baud_tick_gen: FRAC_W must be >= 1 and DIV_FRAC >= 0");
   end

   logic [DIV_W-1:0] cnt;
   logic [OS_W-1:0]  os_cnt;
   logic             pend_vld;
   logic [DIV_W-1:0] pend_val;
   logic             extra;      // stretch the current period by one cycle
   logic             wr_ok;
   logic [DIV_W:0]   last;
   logic             wrap;
   logic [DIV_W-1:0] next_div;

`ifdef FRAC_DIV_EN
   logic [FRAC_W-1:0] acc;
`else
   assign extra = 1'b0;
`endif

   assign wr_ok = div_wr && (div_in >= DIV_W'(2));

   // Terminal count is computed one bit wider so D+1 periods never overflow.
   assign last = {1'b0, div_q} - (DIV_W+1)'(1) + {{DIV_W{1'b0}}, extra};
   assign wrap = ({1'b0, cnt} == last);

   // A write in the same cycle as the apply point beats the older pending value.
   assign next_div = wr_ok    ? div_in   :
                     pend_vld ? pend_val : div_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         os_cnt   <= '0;
         pend_vld <= 1'b0;
         pend_val <= '0;
         div_q    <= RESET_DIV_V;
         div_err  <= 1'b0;
         os_tick  <= 1'b0;
         mid_tick <= 1'b0;
         bit_tick <= 1'b0;
         baud_clk <= 1'b0;
`ifdef FRAC_DIV_EN
         acc      <= '0;
         extra    <= 1'b0;
`endif
      end else begin
         os_tick  <= 1'b0;
         mid_tick <= 1'b0;
         bit_tick <= 1'b0;
         div_err  <= div_wr && !wr_ok;

         if (restart) begin
            // Realign phase; the pending (or simultaneous) divisor takes effect now.
            cnt      <= '0;
            os_cnt   <= '0;
            baud_clk <= 1'b0;
            div_q    <= next_div;
            pend_vld <= 1'b0;
`ifdef FRAC_DIV_EN
            acc      <= '0;
            extra    <= 1'b0;
`endif
         end else begin
            if (wr_ok) begin
               pend_vld <= 1'b1;
               pend_val <= div_in;
            end
            if (en) begin
               if (wrap) begin
                  cnt      <= '0;
                  os_tick  <= 1'b1;
                  mid_tick <= (os_cnt == OS_MID);
                  bit_tick <= (os_cnt == OS_LAST);
                  os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
                  baud_clk <= ~baud_clk;
                  // Divisor changes only on the wrap so no period is ever cut short.
                  div_q    <= next_div;
                  pend_vld <= 1'b0;
`ifdef FRAC_DIV_EN
                  {extra, acc} <= {1'b0, acc} + (FRAC_W+1)'(DIV_FRAC);
`endif
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
         end
      end
   end

endmodule
